hoeraa_adder: RTL and testbench



---
 rtl/hoeraa_pkg.sv | 36 +++
 rtl/hoeraa_exact_rca.sv | 23 ++
 rtl/hoeraa_adder.sv | 91 +++++++++
 tb/tb_hoeraa_adder.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/hoeraa_pkg.sv
// Shared constants and lower-part approximation for the HOERAA adder.
package hoeraa_pkg;

  localparam int unsigned HOERAA_N_DEF = 16;
  localparam int unsigned HOERAA_K_DEF = 10;
  localparam int unsigned HOERAA_MAX_W = 64;

  typedef logic [HOERAA_MAX_W-1:0] hoeraa_wide_t;

  typedef struct packed {
    logic         cin;
    hoeraa_wide_t lsb;
  } hoeraa_lsb_t;

  // Lower k bits: bit k-1 is XOR, bits below are OR; both are forced high when
  // bit k-2 of both operands is set. Bits at and above k are returned as zero.
  function automatic hoeraa_lsb_t hoeraa_approx_lsb(input hoeraa_wide_t x,
                                                    input hoeraa_wide_t y,
                                                    input int unsigned  k);
    hoeraa_lsb_t  r;
    hoeraa_wide_t top_bit;
    hoeraa_wide_t g_bit;
    hoeraa_wide_t lo_mask;
    hoeraa_wide_t g_all;
    logic         g;
    top_bit = hoeraa_wide_t'(1) << (k - 1);
    g_bit   = hoeraa_wide_t'(1) << (k - 2);
    lo_mask = top_bit - hoeraa_wide_t'(1);
    g       = |(x & y & g_bit);
    g_all   = {HOERAA_MAX_W{g}};
    r.cin   = |(x & y & top_bit);
    r.lsb   = ((x | y | g_all) & lo_mask) | (((x ^ y) | g_all) & top_bit);
    return r;
  endfunction

endpackage

// File: rtl/hoeraa_exact_rca.sv
// W-bit exact ripple-carry adder with carry-in and carry-out.
module hoeraa_exact_rca #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);

  logic [W:0] c;

  assign c[0] = cin_i;

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
  end

  assign cout_o = c[W];

endmodule

// File: rtl/hoeraa_adder.sv
// Registered HOERAA approximate adder: exact upper N-K bits, OR-approximated lower K bits.
// Optional HOERAA_ERR_FLAG_EN adds port err flagging any deviation from the exact sum.
module hoeraa_adder
  import hoeraa_pkg::*;
#(
  parameter int unsigned N = HOERAA_N_DEF,
  parameter int unsigned K = HOERAA_K_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [N-1:0] X,
  input  logic [N-1:0] Y,
  output logic         out_valid,
  output logic [N-1:0] S,
  output logic         Co
`ifdef HOERAA_ERR_FLAG_EN
  ,
  output logic         err
`endif
);

  if (N < 3 || K < 2 || K > N || N > HOERAA_MAX_W) begin : g_bad_params
    $error("hoeraa_adder: illegal parameters N=%0d K=%0d", N, K);
  end

  hoeraa_lsb_t  lsb_res;
  logic [N-1:0] S_d, S_q;
  logic         Co_d, Co_q;
  logic         vld_q;

  assign lsb_res      = hoeraa_approx_lsb(hoeraa_wide_t'(X), hoeraa_wide_t'(Y), K);
  assign S_d[K-1:0]   = K'(lsb_res.lsb);

  if (K < N) begin : g_upper
    hoeraa_exact_rca #(.W(N - K)) u_upper (
      .a_i    (X[N-1:K]),
      .b_i    (Y[N-1:K]),
      .cin_i  (lsb_res.cin),
      .sum_o  (S_d[N-1:K]),
      .cout_o (Co_d)
    );
  end else begin : g_no_upper
    assign Co_d = lsb_res.cin;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      S_q   <= '0;
      Co_q  <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= in_valid;
      if (in_valid) begin
        S_q  <= S_d;
        Co_q <= Co_d;
      end
    end
  end

  assign S         = S_q;
  assign Co        = Co_q;
  assign out_valid = vld_q;

`ifdef HOERAA_ERR_FLAG_EN
  logic [N-1:0] ref_sum;
  logic         ref_co;
  logic         err_d, err_q;

  hoeraa_exact_rca #(.W(N)) u_ref (
    .a_i    (X),
    .b_i    (Y),
    .cin_i  (1'b0),
    .sum_o  (ref_sum),
    .cout_o (ref_co)
  );

  assign err_d = ({Co_d, S_d} != {ref_co, ref_sum});

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (in_valid) begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_hoeraa_adder.sv
// Scoreboard bench for hoeraa_adder (N=16, K=10) with random and directed vectors.
module tb_hoeraa_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] X, Y;
  logic        out_valid;
  logic [15:0] S;
  logic        Co;
`ifdef HOERAA_ERR_FLAG_EN
  logic        err;
`endif

  hoeraa_adder #(.N(16), .K(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .X         (X),
    .Y         (Y),
    .out_valid (out_valid),
    .S         (S),
    .Co        (Co)
`ifdef HOERAA_ERR_FLAG_EN
    ,
    .err       (err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] s;
    logic        co;
    logic        e;
  } exp_t;

  exp_t q[$];
  exp_t hold;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 0;
  bit   rst_seen = 0;

  // Reference written from the arithmetic rules, not from the RTL structure.
  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y);
    exp_t        m;
    int unsigned xi, yi, g, cin, low, s9, up, full;
    xi   = x;
    yi   = y;
    g    = (xi >> 8) & (yi >> 8) & 1;
    cin  = (xi >> 9) & (yi >> 9) & 1;
    low  = (g != 0) ? 'h1FF : ((xi | yi) & 'h1FF);
    s9   = (((xi ^ yi) >> 9) & 1) | g;
    up   = (xi >> 10) + (yi >> 10) + cin;
    full = (up << 10) | (s9 << 9) | low;
    m.s  = full[15:0];
    m.co = full[16];
    m.e  = (full != xi + yi);
    return m;
  endfunction

  task automatic cmp(input string name, input exp_t e);
    checks++;
    if (S !== e.s || Co !== e.co
`ifdef HOERAA_ERR_FLAG_EN
        || err !== e.e
`endif
       ) begin
      errors++;
`ifdef HOERAA_ERR_FLAG_EN
      $display("FAIL %s: got S=%h Co=%b err=%b, expected S=%h Co=%b err=%b",
               name, S, Co, err, e.s, e.co, e.e);
`else
      $display("FAIL %s: got S=%h Co=%b, expected S=%h Co=%b", name, S, Co, e.s, e.co);
`endif
    end
  endtask

  task automatic drive(input logic [15:0] x, input logic [15:0] y,
                       input logic v, input logic r);
    @(posedge clk);
    #1;
    X = x;
    Y = y;
    in_valid = v;
    rst = r;
    if (v && !r) q.push_back(model(x, y));
  endtask

  always @(posedge clk) begin
    rst_seen = rst;
    if (rst) mon_en = 1;
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (rst_seen) begin
        hold = '{s: 16'h0, co: 1'b0, e: 1'b0};
        checks++;
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL reset_valid: got out_valid=%b, expected 0", out_valid);
        end
      end
      if (out_valid === 1'b1 && !rst_seen) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got out_valid=1, expected 0 (no pending result)");
        end else begin
          hold = q.pop_front();
          cmp("result", hold);
        end
      end else begin
        cmp(rst_seen ? "reset_state" : "hold", hold);
      end
    end
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    X = '0;
    Y = '0;
    drive(16'h0, 16'h0, 1'b0, 1'b1);
    drive(16'h0, 16'h0, 1'b0, 1'b1);
    drive(16'h0, 16'h0, 1'b0, 1'b0);

    // Listed vectors back-to-back, then lower-part boundary patterns.
    drive(16'h0001, 16'h0001, 1'b1, 1'b0);
    drive(16'h00FF, 16'h00FF, 1'b1, 1'b0);
    drive(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    drive(16'h5555, 16'hAAAA, 1'b1, 1'b0);
    drive(16'h8001, 16'h0101, 1'b1, 1'b0);
    drive(16'h0100, 16'h0100, 1'b1, 1'b0);
    drive(16'h0200, 16'h0200, 1'b1, 1'b0);
    drive(16'hFC00, 16'h0600, 1'b1, 1'b0);
    drive(16'h0000, 16'h0000, 1'b0, 1'b0);
    drive(16'h0000, 16'h0000, 1'b0, 1'b0);

    // Reset overrides an accepted input mid-stream.
    drive(16'h1234, 16'h4321, 1'b1, 1'b0);
    drive(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
    drive(16'h0F0F, 16'h3030, 1'b1, 1'b0);

    for (int i = 0; i < 400; i++) begin
      drive(16'($urandom), 16'($urandom), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 49) == 0));
    end

    for (int i = 0; i < 3; i++) drive(16'h0, 16'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending results, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
